// File: rtl/vga_timing_pkg.sv
// Shared constants and helpers for the VGA timing generator.
// Holds the default 640x480@60 timing, a function that derives the total
// length and sync window of one axis, and a counter width check.
package vga_timing_pkg;

  // Default 640x480 timing, in pixels (horizontal) and lines (vertical).
  localparam int DEF_CLK_DIV  = 4;
  localparam int DEF_CNT_W    = 10;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  // Derived timing of one axis; sync_end is inclusive.
  typedef struct packed {
    int unsigned total;
    int unsigned sync_start;
    int unsigned sync_end;
  } axis_timing_t;

  function automatic axis_timing_t axis_timing(input int unsigned active,
                                               input int unsigned fp,
                                               input int unsigned sync,
                                               input int unsigned bp);
    axis_timing_t t;
    t.total      = active + fp + sync + bp;
    t.sync_start = active + fp;
    t.sync_end   = active + fp + sync - 1;
    return t;
  endfunction

  // A counter of width w can hold 0..total-1 when total <= 2^w.
  function automatic bit fits_cnt_w(input int unsigned total, input int unsigned w);
    longint unsigned cap;
    cap = 64'd1 << w;
    return ({32'd0, total} <= cap);
  endfunction

endpackage

// File: rtl/vga_pix_div.sv
// Pixel-rate divider: div_cnt runs 0..CLK_DIV-1 while en is high.
// tick is the combinational advance request used by the counters on the
// same edge; pix_tick is its registered, one-clock-wide output copy.
module vga_pix_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick,
  output logic pix_tick
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt;

  assign tick = en && (div_cnt == DIV_LAST);

  // Divider count and registered tick; en=0 holds the phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt  <= '0;
      pix_tick <= 1'b0;
    end else begin
      pix_tick <= tick;
      if (en) begin
        if (tick) div_cnt <= '0;
        else      div_cnt <= div_cnt + DIV_W'(1);
      end
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator.
// Divides clk into a pixel tick, counts horizontal/vertical position and
// drives sync, video_on, coordinates and line/frame strobes. Every output is
// registered from the next-state counter values, so sync and video_on change
// on the same edge as pixel_x/pixel_y.
// Optional feature: define VTG_FRAME_CNT_EN to add the 16-bit frame_cnt port.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int   CLK_DIV   = DEF_CLK_DIV,
  parameter int   CNT_W     = DEF_CNT_W,
  parameter int   H_ACTIVE  = DEF_H_ACTIVE,
  parameter int   H_FP      = DEF_H_FP,
  parameter int   H_SYNC    = DEF_H_SYNC,
  parameter int   H_BP      = DEF_H_BP,
  parameter int   V_ACTIVE  = DEF_V_ACTIVE,
  parameter int   V_FP      = DEF_V_FP,
  parameter int   V_SYNC    = DEF_V_SYNC,
  parameter int   V_BP      = DEF_V_BP,
  parameter logic HSYNC_POL = 1'b0,
  parameter logic VSYNC_POL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic             pix_tick,
  output logic             hsync,
  output logic             vsync,
  output logic             video_on,
  output logic [CNT_W-1:0] pixel_x,
  output logic [CNT_W-1:0] pixel_y,
  output logic             line_start,
  output logic             frame_start
`ifdef VTG_FRAME_CNT_EN
  ,
  output logic [15:0]      frame_cnt
`endif
);

  localparam axis_timing_t H_T = axis_timing(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam axis_timing_t V_T = axis_timing(V_ACTIVE, V_FP, V_SYNC, V_BP);

  localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_T.total - 1);
  localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_T.total - 1);
  localparam logic [CNT_W-1:0] H_ACT_C    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT_C    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_START_C = CNT_W'(H_T.sync_start);
  localparam logic [CNT_W-1:0] HS_END_C   = CNT_W'(H_T.sync_end);
  localparam logic [CNT_W-1:0] VS_START_C = CNT_W'(V_T.sync_start);
  localparam logic [CNT_W-1:0] VS_END_C   = CNT_W'(V_T.sync_end);

  // Elaboration-time sanity checks on the parameter set.
  if (CLK_DIV < 1) begin : g_div_err
    $error("vga_timing_gen: CLK_DIV must be at least 1");
  end
  if (!fits_cnt_w(H_T.total, CNT_W) || !fits_cnt_w(V_T.total, CNT_W)) begin : g_width_err
    $error("vga_timing_gen: H_TOTAL or V_TOTAL does not fit in CNT_W bits");
  end

  logic             tick;
  logic [CNT_W-1:0] h_nxt;
  logic [CNT_W-1:0] v_nxt;
  logic             h_wrap;
  logic             hs_win;
  logic             vs_win;

  vga_pix_div #(
    .CLK_DIV (CLK_DIV)
  ) u_pix_div (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .tick     (tick),
    .pix_tick (pix_tick)
  );

  // Next-state position: h advances per tick, v advances when h wraps.
  always_comb begin
    h_nxt  = pixel_x;
    v_nxt  = pixel_y;
    h_wrap = 1'b0;
    if (tick) begin
      if (pixel_x == H_LAST) begin
        h_nxt  = '0;
        h_wrap = 1'b1;
        if (pixel_y == V_LAST) v_nxt = '0;
        else                   v_nxt = pixel_y + CNT_W'(1);
      end else begin
        h_nxt = pixel_x + CNT_W'(1);
      end
    end
  end

  // Sync windows decoded from the next-state position.
  always_comb begin
    hs_win = (h_nxt >= HS_START_C) && (h_nxt <= HS_END_C);
    vs_win = (v_nxt >= VS_START_C) && (v_nxt <= VS_END_C);
  end

  // Position counters and all decoded outputs, registered together.
  always_ff @(posedge clk) begin
    if (rst) begin
      pixel_x     <= '0;
      pixel_y     <= '0;
      hsync       <= ~HSYNC_POL;
      vsync       <= ~VSYNC_POL;
      video_on    <= 1'b1;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      pixel_x     <= h_nxt;
      pixel_y     <= v_nxt;
      hsync       <= hs_win ? HSYNC_POL : ~HSYNC_POL;
      vsync       <= vs_win ? VSYNC_POL : ~VSYNC_POL;
      video_on    <= (h_nxt < H_ACT_C) && (v_nxt < V_ACT_C);
      line_start  <= h_wrap;
      frame_start <= h_wrap && (v_nxt == '0);
    end
  end

`ifdef VTG_FRAME_CNT_EN
  // Completed-frame counter, stepped by the same condition as frame_start.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt <= 16'd0;
    end else if (h_wrap && (v_nxt == '0)) begin
      frame_cnt <= frame_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Testbench for vga_timing_gen: three instances (default 640x480 timing,
// a tiny CLK_DIV=1 active-high-hsync timing, and a small CLK_DIV=3 timing)
// checked by directed scenarios and a randomized run against a model that
// treats position as a plain tick count since reset.
module tb_vga_timing_gen;

  localparam int ND = 3;
  localparam int CD  [ND] = '{4, 1, 3};
  localparam int HA  [ND] = '{640, 8, 20};
  localparam int HF  [ND] = '{16, 2, 3};
  localparam int HSW [ND] = '{96, 2, 4};
  localparam int HB  [ND] = '{48, 2, 5};
  localparam int VA  [ND] = '{480, 4, 10};
  localparam int VF  [ND] = '{10, 1, 2};
  localparam int VSW [ND] = '{2, 1, 3};
  localparam int VB  [ND] = '{33, 1, 4};
  localparam int HP  [ND] = '{0, 1, 0};
  localparam int VP  [ND] = '{0, 0, 0};

  logic       clk = 1'b0;
  logic       rst  [ND];
  logic       en   [ND];
  logic       tick [ND];
  logic       hs   [ND];
  logic       vs   [ND];
  logic       von  [ND];
  logic [9:0] px   [ND];
  logic [9:0] py   [ND];
  logic       ls   [ND];
  logic       fs   [ND];
`ifdef VTG_FRAME_CNT_EN
  logic [15:0] fc  [ND];
`endif

  int errors = 0;
  int checks = 0;

  // Reference model state: ticks since reset, enabled clocks since reset.
  int   n     [ND];
  int   ec    [ND];
  logic m_tick[ND];
  logic m_ls  [ND];
  logic m_fs  [ND];
  int   m_fc  [ND];

  always #5 clk = ~clk;

  for (genvar g = 0; g < ND; g++) begin : g_dut
    vga_timing_gen #(
      .CLK_DIV   (CD[g]),
      .CNT_W     (10),
      .H_ACTIVE  (HA[g]),
      .H_FP      (HF[g]),
      .H_SYNC    (HSW[g]),
      .H_BP      (HB[g]),
      .V_ACTIVE  (VA[g]),
      .V_FP      (VF[g]),
      .V_SYNC    (VSW[g]),
      .V_BP      (VB[g]),
      .HSYNC_POL (HP[g] != 0),
      .VSYNC_POL (VP[g] != 0)
    ) u_dut (
      .clk         (clk),
      .rst         (rst[g]),
      .en          (en[g]),
      .pix_tick    (tick[g]),
      .hsync       (hs[g]),
      .vsync       (vs[g]),
      .video_on    (von[g]),
      .pixel_x     (px[g]),
      .pixel_y     (py[g]),
      .line_start  (ls[g]),
      .frame_start (fs[g])
`ifdef VTG_FRAME_CNT_EN
      ,
      .frame_cnt   (fc[g])
`endif
    );
  end

  function automatic int ht(int d); return HA[d] + HF[d] + HSW[d] + HB[d]; endfunction
  function automatic int vt(int d); return VA[d] + VF[d] + VSW[d] + VB[d]; endfunction
  function automatic int eh(int d); return n[d] % ht(d); endfunction
  function automatic int ev(int d); return (n[d] / ht(d)) % vt(d); endfunction

  function automatic logic ehs(int d);
    bit inwin;
    inwin = (eh(d) >= HA[d] + HF[d]) && (eh(d) < HA[d] + HF[d] + HSW[d]);
    return inwin ? (HP[d] != 0) : (HP[d] == 0);
  endfunction

  function automatic logic evs(int d);
    bit inwin;
    inwin = (ev(d) >= VA[d] + VF[d]) && (ev(d) < VA[d] + VF[d] + VSW[d]);
    return inwin ? (VP[d] != 0) : (VP[d] == 0);
  endfunction

  function automatic logic evon(int d);
    return (eh(d) < HA[d]) && (ev(d) < VA[d]);
  endfunction

  // One clock: model follows the inputs seen at the edge, sample at negedge.
  task automatic step();
    @(posedge clk);
    for (int d = 0; d < ND; d++) begin
      if (rst[d]) begin
        n[d] = 0; ec[d] = 0; m_fc[d] = 0;
        m_tick[d] = 1'b0; m_ls[d] = 1'b0; m_fs[d] = 1'b0;
      end else if (en[d]) begin
        ec[d]++;
        if (ec[d] % CD[d] == 0) begin
          n[d]++;
          m_tick[d] = 1'b1;
          m_ls[d]   = (n[d] % ht(d) == 0);
          m_fs[d]   = (n[d] % (ht(d) * vt(d)) == 0);
          if (m_fs[d]) m_fc[d] = (m_fc[d] + 1) % 65536;
        end else begin
          m_tick[d] = 1'b0; m_ls[d] = 1'b0; m_fs[d] = 1'b0;
        end
      end else begin
        m_tick[d] = 1'b0; m_ls[d] = 1'b0; m_fs[d] = 1'b0;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    for (int d = 0; d < ND; d++) begin rst[d] = 1'b1; en[d] = 1'b0; end
    repeat (3) step();
    for (int d = 0; d < ND; d++) rst[d] = 1'b0;
    for (int d = 0; d < ND; d++) begin
      checks++;
      if (px[d] !== 10'd0 || py[d] !== 10'd0) begin
        errors++; $display("FAIL reset_pos dut%0d: got (%0d,%0d) want (0,0)", d, px[d], py[d]);
      end
      checks++;
      if (hs[d] !== (HP[d] == 0) || vs[d] !== (VP[d] == 0)) begin
        errors++; $display("FAIL reset_sync dut%0d: got hs=%b vs=%b want inactive", d, hs[d], vs[d]);
      end
      checks++;
      if (von[d] !== 1'b1) begin
        errors++; $display("FAIL reset_video_on dut%0d: got %b want 1", d, von[d]);
      end
      checks++;
      if (tick[d] !== 1'b0 || ls[d] !== 1'b0 || fs[d] !== 1'b0) begin
        errors++; $display("FAIL reset_strobes dut%0d: got %b%b%b want 000", d, tick[d], ls[d], fs[d]);
      end
    end
  endtask

  task automatic test_hsync_default();
    int cyc = 0, fall_cyc = -1, rise_cyc = -1, fall_x = -1, rise_x = -1;
    int ls1 = -1, ls2 = -1, last_tick = -1;
    bit von_seen = 0;
    logic prev_hs;
    prev_hs = hs[0];
    en[0] = 1'b1;
    while (ls2 < 0 && cyc < 7000) begin
      step(); cyc++;
      if (prev_hs === 1'b1 && hs[0] === 1'b0 && fall_cyc < 0) begin
        fall_cyc = cyc; fall_x = int'(px[0]);
      end
      if (prev_hs === 1'b0 && hs[0] === 1'b1 && fall_cyc >= 0 && rise_cyc < 0) begin
        rise_cyc = cyc; rise_x = int'(px[0]);
      end
      prev_hs = hs[0];
      if (tick[0] === 1'b1) begin
        if (last_tick >= 0) begin
          checks++;
          if (cyc - last_tick != 4) begin
            errors++; $display("FAIL tick_period: got %0d want 4", cyc - last_tick);
          end
        end
        last_tick = cyc;
      end
      if (px[0] == 10'd640 && !von_seen) begin
        von_seen = 1;
        checks++;
        if (von[0] !== 1'b0) begin
          errors++; $display("FAIL video_on_x640: got %b want 0", von[0]);
        end
      end
      if (ls[0] === 1'b1) begin
        if (ls1 < 0) ls1 = cyc; else ls2 = cyc;
      end
    end
    checks++;
    if (fall_cyc != 2624 || fall_x != 656) begin
      errors++; $display("FAIL hsync_fall: got clk=%0d x=%0d want clk=2624 x=656", fall_cyc, fall_x);
    end
    checks++;
    if (rise_cyc - fall_cyc != 384 || rise_x != 752) begin
      errors++; $display("FAIL hsync_width: got %0d clks x=%0d want 384 x=752", rise_cyc - fall_cyc, rise_x);
    end
    checks++;
    if (ls1 != 3200 || ls2 - ls1 != 3200) begin
      errors++; $display("FAIL line_period: got first=%0d period=%0d want 3200/3200", ls1, ls2 - ls1);
    end
    checks++;
    if (!von_seen) begin
      errors++; $display("FAIL video_on_x640: got never reached want reached");
    end
  endtask

  task automatic test_freeze();
    int guard = 0, cnt = 0;
    logic [9:0] sx, sy;
    logic shs, svs, svon;
    while (!(px[0] == 10'd100 && tick[0] === 1'b1) && guard < 4000) begin step(); guard++; end
    checks++;
    if (guard >= 4000) begin
      errors++; $display("FAIL freeze_reach: got timeout want x=100");
      return;
    end
    step();
    sx = px[0]; sy = py[0]; shs = hs[0]; svs = vs[0]; svon = von[0];
    en[0] = 1'b0;
    for (int i = 0; i < 50; i++) begin
      step();
      checks++;
      if (px[0] !== sx || py[0] !== sy || hs[0] !== shs || vs[0] !== svs || von[0] !== svon) begin
        errors++; $display("FAIL freeze_hold: got (%0d,%0d) want (%0d,%0d) held", px[0], py[0], sx, sy);
      end
      checks++;
      if ((tick[0] | ls[0] | fs[0]) !== 1'b0) begin
        errors++; $display("FAIL freeze_strobe: got %b%b%b want 000", tick[0], ls[0], fs[0]);
      end
    end
    en[0] = 1'b1;
    while (px[0] == sx && cnt < 10) begin step(); cnt++; end
    checks++;
    if (cnt != 3 || px[0] !== 10'd101 || tick[0] !== 1'b1) begin
      errors++; $display("FAIL freeze_resume: got %0d clks x=%0d tick=%b want 3 clks x=101 tick=1", cnt, px[0], tick[0]);
    end
    en[0] = 1'b0;
  endtask

  task automatic test_frame();
    int cyc = 0, nfs = 0, von_cnt = 0, vs_run = 0, vs_len = -1, vs_fall_y = -1;
    int fs_t [3];
    logic prev_vs;
    rst[2] = 1'b1; step(); rst[2] = 1'b0;
    en[2] = 1'b1;
    prev_vs = vs[2];
    fs_t = '{-1, -1, -1};
    while (nfs < 3 && cyc < 6000) begin
      step(); cyc++;
      if (fs[2] === 1'b1) begin fs_t[nfs] = cyc; nfs++; end
      if (nfs == 1) begin
        if (von[2] === 1'b1) von_cnt++;
        if (prev_vs === 1'b1 && vs[2] === 1'b0 && vs_fall_y < 0) begin
          vs_fall_y = int'(py[2]); vs_run = 0;
        end
        if (vs[2] === 1'b0 && vs_fall_y >= 0 && vs_len < 0) vs_run++;
        if (prev_vs === 1'b0 && vs[2] === 1'b1 && vs_fall_y >= 0 && vs_len < 0) vs_len = vs_run;
      end
      if (px[2] == 10'd20 || py[2] == 10'd10) begin
        checks++;
        if (von[2] !== 1'b0) begin
          errors++; $display("FAIL blank_edge: got video_on=%b at (%0d,%0d) want 0", von[2], px[2], py[2]);
        end
      end
      prev_vs = vs[2];
    end
    checks++;
    if (nfs != 3) begin
      errors++; $display("FAIL frame_count: got %0d frame_starts want 3", nfs);
    end
    checks++;
    if (fs_t[0] != 1824 || fs_t[1] - fs_t[0] != 1824 || fs_t[2] - fs_t[1] != 1824) begin
      errors++; $display("FAIL frame_period: got %0d/%0d/%0d want 1824 apart", fs_t[0], fs_t[1], fs_t[2]);
    end
    checks++;
    if (von_cnt != 600) begin
      errors++; $display("FAIL video_on_count: got %0d want 600", von_cnt);
    end
    checks++;
    if (vs_len != 288 || vs_fall_y != 12) begin
      errors++; $display("FAIL vsync_window: got len=%0d y=%0d want 288 y=12", vs_len, vs_fall_y);
    end
  endtask

  task automatic test_mid_reset();
    int guard = 0, cnt = 0, r = 0;
    while (!(px[2] == 10'd25 && py[2] == 10'd13) && guard < 2500) begin step(); guard++; end
    checks++;
    if (hs[2] !== 1'b0 || vs[2] !== 1'b0) begin
      errors++; $display("FAIL pre_reset_sync: got hs=%b vs=%b at (%0d,%0d) want 0 0", hs[2], vs[2], px[2], py[2]);
    end
    rst[2] = 1'b1; step(); rst[2] = 1'b0;
    checks++;
    if (px[2] !== 10'd0 || py[2] !== 10'd0 || hs[2] !== 1'b1 || vs[2] !== 1'b1 || von[2] !== 1'b1) begin
      errors++; $display("FAIL mid_reset_state: got (%0d,%0d) hs=%b vs=%b von=%b want (0,0) 1 1 1",
                         px[2], py[2], hs[2], vs[2], von[2]);
    end
    checks++;
    if (fs[2] !== 1'b0 || ls[2] !== 1'b0 || tick[2] !== 1'b0) begin
      errors++; $display("FAIL mid_reset_strobe: got %b%b%b want 000", tick[2], ls[2], fs[2]);
    end
    while (px[2] == 10'd0 && cnt < 10) begin
      step(); cnt++; r++;
      checks++;
      if (fs[2] !== 1'b0 || ls[2] !== 1'b0) begin
        errors++; $display("FAIL mid_reset_nostrobe: got ls=%b fs=%b want 0 0", ls[2], fs[2]);
      end
    end
    checks++;
    if (cnt != 3 || px[2] !== 10'd1) begin
      errors++; $display("FAIL mid_reset_first_tick: got %0d clks x=%0d want 3 x=1", cnt, px[2]);
    end
    while (ls[2] !== 1'b1 && r < 300) begin step(); r++; end
    checks++;
    if (r != 96 || py[2] !== 10'd1) begin
      errors++; $display("FAIL mid_reset_line: got ls at %0d y=%0d want 96 y=1", r, py[2]);
    end
    en[2] = 1'b0;
  endtask

  task automatic test_small();
    int nfs = 0;
    logic exp_hs;
    rst[1] = 1'b1; step(); rst[1] = 1'b0;
    en[1] = 1'b1;
    for (int i = 0; i < 294; i++) begin
      step();
      exp_hs = (px[1] >= 10'd10) && (px[1] <= 10'd11);
      checks++;
      if (hs[1] !== exp_hs) begin
        errors++; $display("FAIL small_hsync: got %b at x=%0d want %b", hs[1], px[1], exp_hs);
      end
      if (fs[1] === 1'b1) nfs++;
    end
    checks++;
    if (nfs != 3 || px[1] !== 10'd0 || py[1] !== 10'd0 || fs[1] !== 1'b1) begin
      errors++; $display("FAIL small_frames: got %0d frames at (%0d,%0d) want 3 at (0,0)", nfs, px[1], py[1]);
    end
`ifdef VTG_FRAME_CNT_EN
    checks++;
    if (fc[1] !== 16'd3) begin
      errors++; $display("FAIL small_frame_cnt: got %0d want 3", fc[1]);
    end
`endif
    en[1] = 1'b0;
  endtask

  task automatic test_random();
    for (int d = 0; d < ND; d++) rst[d] = 1'b1;
    step();
    for (int i = 0; i < 20000; i++) begin
      for (int d = 0; d < ND; d++) begin
        en[d]  = ($urandom_range(0, 9) != 0);
        rst[d] = ($urandom_range(0, 999) == 0);
      end
      step();
      for (int d = 0; d < ND; d++) begin
        checks++;
        if (px[d] !== 10'(eh(d)) || py[d] !== 10'(ev(d))) begin
          errors++; $display("FAIL rand_pos dut%0d: got (%0d,%0d) want (%0d,%0d)", d, px[d], py[d], eh(d), ev(d));
        end
        checks++;
        if (hs[d] !== ehs(d) || vs[d] !== evs(d)) begin
          errors++; $display("FAIL rand_sync dut%0d: got hs=%b vs=%b want %b %b", d, hs[d], vs[d], ehs(d), evs(d));
        end
        checks++;
        if (von[d] !== evon(d)) begin
          errors++; $display("FAIL rand_video_on dut%0d: got %b want %b", d, von[d], evon(d));
        end
        checks++;
        if (tick[d] !== m_tick[d] || ls[d] !== m_ls[d] || fs[d] !== m_fs[d]) begin
          errors++; $display("FAIL rand_strobes dut%0d: got %b%b%b want %b%b%b",
                             d, tick[d], ls[d], fs[d], m_tick[d], m_ls[d], m_fs[d]);
        end
`ifdef VTG_FRAME_CNT_EN
        checks++;
        if (fc[d] !== 16'(m_fc[d])) begin
          errors++; $display("FAIL rand_frame_cnt dut%0d: got %0d want %0d", d, fc[d], m_fc[d]);
        end
`endif
      end
    end
  endtask

  initial begin
    for (int d = 0; d < ND; d++) begin
      rst[d] = 1'b1; en[d] = 1'b0;
      n[d] = 0; ec[d] = 0; m_fc[d] = 0;
      m_tick[d] = 1'b0; m_ls[d] = 1'b0; m_fs[d] = 1'b0;
    end
    @(negedge clk);
    test_reset();
    test_hsync_default();
    test_freeze();
    test_frame();
    test_mid_reset();
    test_small();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
